ysyx_25040111_lsu_axi: RTL and testbench

//  Memory-side responder for the core's LSU request interface (lsu_r*/lsu_w*), driven by the load/store/fetch arbiter.

---
 rtl/ysyx_25040111_lsu_axi_pkg.sv | 55 +++++
 rtl/ysyx_25040111_lsu_align.sv | 69 ++++++
 rtl/ysyx_25040111_lsu_axi.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_ysyx_25040111_lsu_axi.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040111_lsu_axi_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_25040111_lsu_axi_pkg
//   Shared definitions for the LSU-to-AXI4 responder:
//     - AXI4 burst / size / response encodings
//     - LSU access-size enum (byte / half / word) and its decode from the
//       2-bit request mask
//     - FSM state typedef of the responder
//   Optional feature macro used by the top: YSYX_25040111_LSU_FAULT_EN
// ----------------------------------------------------------------------------
package ysyx_25040111_lsu_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [2:0] AXI_SIZE_1B = 3'b000;
    localparam logic [2:0] AXI_SIZE_2B = 3'b001;
    localparam logic [2:0] AXI_SIZE_4B = 3'b010;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'b00,
        LSU_HALF = 2'b01,
        LSU_WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WRITE = 3'd3,
        ST_WRESP = 3'd4
    } lsu_state_e;

    // Request mask encoding: 00 byte, 01 half, 10 and 11 both mean word.
    function automatic lsu_size_e mask_to_size(input logic [1:0] mask);
        lsu_size_e size;
        case (mask)
            2'b00:   size = LSU_BYTE;
            2'b01:   size = LSU_HALF;
            default: size = LSU_WORD;
        endcase
        return size;
    endfunction

    function automatic logic [2:0] size_to_axsize(input lsu_size_e size);
        logic [2:0] axsize;
        case (size)
            LSU_BYTE: axsize = AXI_SIZE_1B;
            LSU_HALF: axsize = AXI_SIZE_2B;
            default:  axsize = AXI_SIZE_4B;
        endcase
        return axsize;
    endfunction

endpackage

// File: rtl/ysyx_25040111_lsu_align.sv
// ----------------------------------------------------------------------------
// ysyx_25040111_lsu_align
//   Purely combinational lane handling between the LSU and the 32-bit bus.
//   Read side : selects the addressed byte/half from the raw bus word and
//               zero- or sign-extends it; burst beats pass through untouched.
//   Write side: replicates narrow store data across all lanes and builds the
//               matching byte strobe.
// Ports
//   r_raw   in  32  raw read data from the bus
//   addr_lo in   2  low address bits of the access
//   size    in      access size (lsu_size_e)
//   sign    in   1  sign-extend narrow loads
//   burst   in   1  burst read: no shifting or extension
//   r_out   out 32  aligned/extended load data
//   w_raw   in  32  LSB-aligned store data
//   w_out   out 32  lane-replicated store data
//   w_strb  out  4  byte strobes
// ----------------------------------------------------------------------------
module ysyx_25040111_lsu_align
    import ysyx_25040111_lsu_axi_pkg::*;
(
    input  logic [31:0] r_raw,
    input  logic [1:0]  addr_lo,
    input  lsu_size_e   size,
    input  logic        sign,
    input  logic        burst,
    output logic [31:0] r_out,
    input  logic [31:0] w_raw,
    output logic [31:0] w_out,
    output logic [3:0]  w_strb
);

    logic [7:0]  r_byte;
    logic [15:0] r_half;

    always_comb begin
        // Half-word lane is chosen by addr[1] only; addr[0] is ignored.
        r_byte = r_raw[{addr_lo, 3'b000} +: 8];
        r_half = r_raw[{addr_lo[1], 4'b0000} +: 16];
        r_out  = r_raw;
        if (!burst) begin
            case (size)
                LSU_BYTE: r_out = {{24{sign & r_byte[7]}}, r_byte};
                LSU_HALF: r_out = {{16{sign & r_half[15]}}, r_half};
                default:  r_out = r_raw;
            endcase
        end
    end

    always_comb begin
        w_out  = w_raw;
        w_strb = 4'b1111;
        case (size)
            LSU_BYTE: begin
                w_out  = {4{w_raw[7:0]}};
                w_strb = 4'b0001 << addr_lo;
            end
            LSU_HALF: begin
                w_out  = {2{w_raw[15:0]}};
                w_strb = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: begin
                w_out  = w_raw;
                w_strb = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_25040111_lsu_axi.sv
// ----------------------------------------------------------------------------
// ysyx_25040111_lsu_axi
//   Memory-side responder for the core's LSU request interface. Accepts one
//   read (single or INCR burst) or one write at a time from the arbiter and
//   turns it into an AXI4 master transaction on io_master_*.
//   Read beats come back as one-cycle lsu_rready pulses with lsu_rdata
//   (single reads aligned/extended, burst beats raw); a write completes with
//   a one-cycle lsu_wready pulse when the B response is taken.
//
// Ports
//   clock, reset               clock; synchronous active-high reset
//   lsu_rvalid/raddr/rlen/burst/rsign/rmask   read request (held until accepted)
//   lsu_rready, lsu_rdata      per-beat return pulse and data
//   lsu_wvalid/waddr/wdata/wmask              write request (held until accepted)
//   lsu_wready                 write-done pulse
//   io_master_ar*/r*/aw*/w*/b* AXI4 master channels
//   lsu_fault, lsu_fault_addr  only with YSYX_25040111_LSU_FAULT_EN defined:
//                              pulse alongside lsu_rready/lsu_wready when the
//                              response is not OKAY, carrying the request address
//
// Handshake rule used throughout: a transfer happens in a cycle where both
// valid and ready are high at the rising clock edge; valid, once raised,
// stays high until that transfer.
// ----------------------------------------------------------------------------
module ysyx_25040111_lsu_axi
    import ysyx_25040111_lsu_axi_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int AXI_ID = 0
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            lsu_rvalid,
    output logic            lsu_rready,
    output logic [31:0]     lsu_rdata,
    input  logic [31:0]     lsu_raddr,
    input  logic [7:0]      lsu_rlen,
    input  logic            lsu_burst,
    input  logic            lsu_rsign,
    input  logic [1:0]      lsu_rmask,

    input  logic            lsu_wvalid,
    output logic            lsu_wready,
    input  logic [31:0]     lsu_wdata,
    input  logic [31:0]     lsu_waddr,
    input  logic [1:0]      lsu_wmask,

    output logic            io_master_ar_valid,
    input  logic            io_master_ar_ready,
    output logic [31:0]     io_master_ar_addr,
    output logic [ID_W-1:0] io_master_ar_id,
    output logic [7:0]      io_master_ar_len,
    output logic [2:0]      io_master_ar_size,
    output logic [1:0]      io_master_ar_burst,

    input  logic            io_master_r_valid,
    output logic            io_master_r_ready,
    input  logic [31:0]     io_master_r_data,
    input  logic [1:0]      io_master_r_resp,
    input  logic            io_master_r_last,
    input  logic [ID_W-1:0] io_master_r_id,

    output logic            io_master_aw_valid,
    input  logic            io_master_aw_ready,
    output logic [31:0]     io_master_aw_addr,
    output logic [ID_W-1:0] io_master_aw_id,
    output logic [7:0]      io_master_aw_len,
    output logic [2:0]      io_master_aw_size,
    output logic [1:0]      io_master_aw_burst,

    output logic            io_master_w_valid,
    input  logic            io_master_w_ready,
    output logic [31:0]     io_master_w_data,
    output logic [3:0]      io_master_w_strb,
    output logic            io_master_w_last,

    input  logic            io_master_b_valid,
    output logic            io_master_b_ready,
    input  logic [1:0]      io_master_b_resp,
    input  logic [ID_W-1:0] io_master_b_id
`ifdef YSYX_25040111_LSU_FAULT_EN
    ,
    output logic            lsu_fault,
    output logic [31:0]     lsu_fault_addr
`endif
);

    // ------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------
    lsu_state_e state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  beat_q, beat_d;
    logic        burst_q, burst_d;
    logic        sign_q, sign_d;
    lsu_size_e   size_q, size_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic [31:0] rd_aligned;
    logic [31:0] wd_replicated;
    logic [3:0]  wd_strb;

    ysyx_25040111_lsu_align u_align (
        .r_raw   (io_master_r_data),
        .addr_lo (addr_q[1:0]),
        .size    (size_q),
        .sign    (sign_q),
        .burst   (burst_q),
        .r_out   (rd_aligned),
        .w_raw   (wdata_q),
        .w_out   (wd_replicated),
        .w_strb  (wd_strb)
    );

    // ------------------------------------------------------------------
    // Static AXI fields, all driven from the latched request
    // ------------------------------------------------------------------
    assign io_master_ar_addr  = addr_q;
    assign io_master_ar_id    = ID_W'(AXI_ID);
    assign io_master_ar_len   = len_q;
    assign io_master_ar_size  = burst_q ? AXI_SIZE_4B : size_to_axsize(size_q);
    assign io_master_ar_burst = AXI_BURST_INCR;

    assign io_master_aw_addr  = addr_q;
    assign io_master_aw_id    = ID_W'(AXI_ID);
    assign io_master_aw_len   = 8'd0;
    assign io_master_aw_size  = size_to_axsize(size_q);
    assign io_master_aw_burst = AXI_BURST_INCR;

    assign io_master_w_data   = wd_replicated;
    assign io_master_w_strb   = wd_strb;
    assign io_master_w_last   = 1'b1;

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        len_d     = len_q;
        beat_d    = beat_q;
        burst_d   = burst_q;
        sign_d    = sign_q;
        size_d    = size_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        io_master_ar_valid = 1'b0;
        io_master_r_ready  = 1'b0;
        io_master_aw_valid = 1'b0;
        io_master_w_valid  = 1'b0;
        io_master_b_ready  = 1'b0;
        lsu_rready         = 1'b0;
        lsu_rdata          = 32'd0;
        lsu_wready         = 1'b0;
`ifdef YSYX_25040111_LSU_FAULT_EN
        lsu_fault          = 1'b0;
        lsu_fault_addr     = 32'd0;
`endif

        case (state_q)
            ST_IDLE: begin
                // Reads take priority; a concurrent write stays pending upstream.
                if (lsu_rvalid) begin
                    addr_d  = lsu_raddr;
                    len_d   = lsu_burst ? lsu_rlen : 8'd0;
                    burst_d = lsu_burst;
                    sign_d  = lsu_rsign;
                    size_d  = mask_to_size(lsu_rmask);
                    beat_d  = 8'd0;
                    state_d = ST_RADDR;
                end else if (lsu_wvalid) begin
                    addr_d    = lsu_waddr;
                    wdata_d   = lsu_wdata;
                    size_d    = mask_to_size(lsu_wmask);
                    burst_d   = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WRITE;
                end
            end

            ST_RADDR: begin
                io_master_ar_valid = 1'b1;
                if (io_master_ar_ready) begin
                    state_d = ST_RDATA;
                end
            end

            ST_RDATA: begin
                io_master_r_ready = 1'b1;
                if (io_master_r_valid) begin
                    lsu_rready = 1'b1;
                    lsu_rdata  = rd_aligned;
`ifdef YSYX_25040111_LSU_FAULT_EN
                    if (io_master_r_resp != AXI_RESP_OKAY) begin
                        lsu_fault      = 1'b1;
                        lsu_fault_addr = addr_q;
                    end
`endif
                    // Either rlast or our own beat count ends the burst, so a
                    // slave that never raises rlast cannot hang the LSU.
                    if (io_master_r_last || (beat_q == len_q)) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end

            ST_WRITE: begin
                io_master_aw_valid = !aw_done_q;
                io_master_w_valid  = !w_done_q;
                aw_done_d = aw_done_q | io_master_aw_ready;
                w_done_d  = w_done_q  | io_master_w_ready;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WRESP;
                end
            end

            ST_WRESP: begin
                io_master_b_ready = 1'b1;
                if (io_master_b_valid) begin
                    lsu_wready = 1'b1;
`ifdef YSYX_25040111_LSU_FAULT_EN
                    if (io_master_b_resp != AXI_RESP_OKAY) begin
                        lsu_fault      = 1'b1;
                        lsu_fault_addr = addr_q;
                    end
`endif
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset abandons the transaction outright: no handshakes with the bus
        // and no completion pulse towards the LSU in the reset cycle.
        if (reset) begin
            state_d            = ST_IDLE;
            io_master_ar_valid = 1'b0;
            io_master_r_ready  = 1'b0;
            io_master_aw_valid = 1'b0;
            io_master_w_valid  = 1'b0;
            io_master_b_ready  = 1'b0;
            lsu_rready         = 1'b0;
            lsu_rdata          = 32'd0;
            lsu_wready         = 1'b0;
`ifdef YSYX_25040111_LSU_FAULT_EN
            lsu_fault          = 1'b0;
            lsu_fault_addr     = 32'd0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            len_q     <= 8'd0;
            beat_q    <= 8'd0;
            burst_q   <= 1'b0;
            sign_q    <= 1'b0;
            size_q    <= LSU_BYTE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            burst_q   <= burst_d;
            sign_q    <= sign_d;
            size_q    <= size_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Response ids (and, without fault reporting, response codes) carry no
    // information for a single-id, one-outstanding master.
`ifdef YSYX_25040111_LSU_FAULT_EN
    logic unused_axi_id;
    assign unused_axi_id = ^{io_master_r_id, io_master_b_id};
`else
    logic unused_axi_resp_id;
    assign unused_axi_resp_id = ^{io_master_r_resp, io_master_b_resp,
                                  io_master_r_id, io_master_b_id};
`endif

endmodule

// File: tb/tb_ysyx_25040111_lsu_axi.sv
module tb_ysyx_25040111_lsu_axi;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        lsu_rvalid = 0, lsu_rready;
    logic [31:0] lsu_rdata;
    logic [31:0] lsu_raddr = 0;
    logic [7:0]  lsu_rlen = 0;
    logic        lsu_burst = 0, lsu_rsign = 0;
    logic [1:0]  lsu_rmask = 0;
    logic        lsu_wvalid = 0, lsu_wready;
    logic [31:0] lsu_wdata = 0, lsu_waddr = 0;
    logic [1:0]  lsu_wmask = 0;

    logic        ar_valid, ar_ready = 0;
    logic [31:0] ar_addr;
    logic [3:0]  ar_id;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid = 0, r_ready;
    logic [31:0] r_data = 0;
    logic [1:0]  r_resp = 0;
    logic        r_last = 0;
    logic [3:0]  r_id = 0;
    logic        aw_valid, aw_ready = 0;
    logic [31:0] aw_addr;
    logic [3:0]  aw_id;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        w_valid, w_ready = 0;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    logic        b_valid = 0, b_ready;
    logic [1:0]  b_resp = 0;
    logic [3:0]  b_id = 0;
`ifdef YSYX_25040111_LSU_FAULT_EN
    logic        lsu_fault;
    logic [31:0] lsu_fault_addr;
`endif

    ysyx_25040111_lsu_axi #(.ID_W(4), .AXI_ID(0)) dut (
        .clock(clock), .reset(reset),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
        .lsu_raddr(lsu_raddr), .lsu_rlen(lsu_rlen), .lsu_burst(lsu_burst),
        .lsu_rsign(lsu_rsign), .lsu_rmask(lsu_rmask),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata),
        .lsu_waddr(lsu_waddr), .lsu_wmask(lsu_wmask),
        .io_master_ar_valid(ar_valid), .io_master_ar_ready(ar_ready),
        .io_master_ar_addr(ar_addr), .io_master_ar_id(ar_id), .io_master_ar_len(ar_len),
        .io_master_ar_size(ar_size), .io_master_ar_burst(ar_burst),
        .io_master_r_valid(r_valid), .io_master_r_ready(r_ready), .io_master_r_data(r_data),
        .io_master_r_resp(r_resp), .io_master_r_last(r_last), .io_master_r_id(r_id),
        .io_master_aw_valid(aw_valid), .io_master_aw_ready(aw_ready),
        .io_master_aw_addr(aw_addr), .io_master_aw_id(aw_id), .io_master_aw_len(aw_len),
        .io_master_aw_size(aw_size), .io_master_aw_burst(aw_burst),
        .io_master_w_valid(w_valid), .io_master_w_ready(w_ready), .io_master_w_data(w_data),
        .io_master_w_strb(w_strb), .io_master_w_last(w_last),
        .io_master_b_valid(b_valid), .io_master_b_ready(b_ready),
        .io_master_b_resp(b_resp), .io_master_b_id(b_id)
`ifdef YSYX_25040111_LSU_FAULT_EN
        , .lsu_fault(lsu_fault), .lsu_fault_addr(lsu_fault_addr)
`endif
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] raw, input logic [1:0] a,
                                               input logic [1:0] m, input logic s);
        logic [31:0] sh;
        logic [31:0] res;
        case (m)
            2'b00: begin
                sh  = raw >> (8 * a);
                res = s ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
            end
            2'b01: begin
                sh  = a[1] ? (raw >> 16) : raw;
                res = s ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
            end
            default: res = raw;
        endcase
        return res;
    endfunction

    // ---------------- AXI slave model (drives at negedge) ----------------
    int          ar_wait = 0, r_gap = 0, aw_wait = 0, w_wait = 0;
    logic [1:0]  rresp_cfg = 0, bresp_cfg = 0;
    logic [31:0] rdata_tbl[16];
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    int          r_left = 0, r_idx = 0, r_gap_cnt = 0;
    logic        aw_got = 0, w_got = 0, b_pend = 0;
    logic [31:0] cap_araddr = 0, cap_awaddr = 0, cap_wdata = 0;
    logic [7:0]  cap_arlen = 0, cap_awlen = 0;
    logic [2:0]  cap_arsize = 0, cap_awsize = 0;
    logic [1:0]  cap_arburst = 0, cap_awburst = 0;
    logic [3:0]  cap_wstrb = 0;
    logic        cap_wlast = 0;
    int          aw_hs_cyc = 0;

    always @(negedge clock) begin
        if (reset) begin
            ar_ready = 0; r_valid = 0; r_last = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
            r_left = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
            aw_got = 0; w_got = 0; b_pend = 0;
        end else begin
            // R beats (processed before AR so data follows the address phase)
            r_valid = 0;
            r_last  = 0;
            if (r_left > 0) begin
                if (r_gap_cnt > 0) begin
                    r_gap_cnt--;
                end else begin
                    r_valid = 1;
                    r_data  = rdata_tbl[r_idx];
                    r_last  = (r_left == 1);
                    r_resp  = rresp_cfg;
                    if (r_ready) begin
                        r_left--;
                        r_idx++;
                        r_gap_cnt = r_gap;
                    end
                end
            end
            ar_ready = 0;
            if (ar_valid) begin
                if (ar_cnt >= ar_wait) begin
                    ar_ready    = 1;
                    cap_araddr  = ar_addr;
                    cap_arlen   = ar_len;
                    cap_arsize  = ar_size;
                    cap_arburst = ar_burst;
                    r_left      = int'(ar_len) + 1;
                    r_idx       = 0;
                    r_gap_cnt   = 0;
                    ar_cnt      = 0;
                end else begin
                    ar_cnt++;
                end
            end
            // B
            b_valid = 0;
            if (b_pend) begin
                b_valid = 1;
                b_resp  = bresp_cfg;
                if (b_ready) b_pend = 0;
            end
            // AW / W
            aw_ready = 0;
            if (aw_valid) begin
                if (aw_cnt >= aw_wait) begin
                    aw_ready    = 1;
                    cap_awaddr  = aw_addr;
                    cap_awlen   = aw_len;
                    cap_awsize  = aw_size;
                    cap_awburst = aw_burst;
                    aw_got      = 1;
                    aw_cnt      = 0;
                    aw_hs_cyc   = cyc;
                end else begin
                    aw_cnt++;
                end
            end
            w_ready = 0;
            if (w_valid) begin
                if (w_cnt >= w_wait) begin
                    w_ready   = 1;
                    cap_wdata = w_data;
                    cap_wstrb = w_strb;
                    cap_wlast = w_last;
                    w_got     = 1;
                    w_cnt     = 0;
                end else begin
                    w_cnt++;
                end
            end
            if (aw_got && w_got) begin
                b_pend = 1;
                aw_got = 0;
                w_got  = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard pop ----------------
    int rready_cnt = 0, wready_cnt = 0;
    int last_r_cyc = 0, last_w_cyc = 0;
`ifdef YSYX_25040111_LSU_FAULT_EN
    int          fault_cnt = 0;
    logic        last_w_fault = 0;
    logic [31:0] last_w_fault_addr = 0;
`endif

    always @(negedge clock) begin
        #2;
        if (lsu_rready) begin
            rready_cnt++;
            last_r_cyc = cyc;
            if (exp_q.size() == 0) check_eq("r_unexpected", exp_q.size(), 1);
            else check_eq("rdata", lsu_rdata, exp_q.pop_front());
        end
        if (lsu_wready) begin
            wready_cnt++;
            last_w_cyc = cyc;
`ifdef YSYX_25040111_LSU_FAULT_EN
            last_w_fault      = lsu_fault;
            last_w_fault_addr = lsu_fault_addr;
`endif
        end
`ifdef YSYX_25040111_LSU_FAULT_EN
        if (lsu_fault) fault_cnt++;
`endif
    end

    // ---------------- driver tasks ----------------
    int acc_cyc = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_read(input logic [31:0] addr, input logic [7:0] len,
                              input logic burst, input logic sign, input logic [1:0] mask);
        lsu_raddr = addr; lsu_rlen = len; lsu_burst = burst;
        lsu_rsign = sign; lsu_rmask = mask; lsu_rvalid = 1;
        acc_cyc = cyc;
    endtask

    task automatic start_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] mask);
        lsu_waddr = addr; lsu_wdata = data; lsu_wmask = mask; lsu_wvalid = 1;
        acc_cyc = cyc;
    endtask

    // Hold the request until the address phase shows it was taken, then
    // scramble the request fields to prove they were latched.
    task automatic wait_accept_r();
        int n = 0;
        while (!ar_valid && n < 60) begin tick(); n++; end
        check_eq("accept_r", ar_valid, 1);
        lsu_rvalid = 0;
        lsu_raddr = $urandom; lsu_rlen = 8'($urandom); lsu_rsign = 1'($urandom);
        lsu_rmask = 2'($urandom); lsu_burst = 1'($urandom);
    endtask

    task automatic wait_accept_w();
        int n = 0;
        while (!aw_valid && n < 60) begin tick(); n++; end
        check_eq("accept_w", aw_valid, 1);
        lsu_wvalid = 0;
        lsu_waddr = $urandom; lsu_wdata = $urandom; lsu_wmask = 2'($urandom);
    endtask

    task automatic wait_r(input int target);
        int n = 0;
        while (rready_cnt < target && n < 300) begin tick(); n++; end
        check_eq("r_pulses", rready_cnt, target);
    endtask

    task automatic wait_w(input int target);
        int n = 0;
        while (wready_cnt < target && n < 300) begin tick(); n++; end
        check_eq("w_pulses", wready_cnt, target);
    endtask

    task automatic do_single_read(input logic [31:0] addr, input logic [1:0] mask,
                                  input logic sign, input logic [31:0] raw,
                                  input logic [7:0] junk_len);
        int base = rready_cnt;
        int acc;
        rdata_tbl[0] = raw;
        exp_q.push_back(model_load(raw, addr[1:0], mask, sign));
        start_read(addr, junk_len, 1'b0, sign, mask);
        acc = acc_cyc;
        wait_accept_r();
        wait_r(base + 1);
        check_eq("r_latency", last_r_cyc - acc, 2 + ar_wait);
        check_eq("araddr", cap_araddr, addr);
        check_eq("arlen_single", cap_arlen, 0);
        check_eq("arsize", cap_arsize, (mask == 2'b00) ? 0 : (mask == 2'b01) ? 1 : 2);
        check_eq("arburst", cap_arburst, 2'b01);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] mask, input logic [31:0] exp_data,
                            input logic [3:0] exp_strb);
        int base = wready_cnt;
        int acc;
        start_write(addr, data, mask);
        acc = acc_cyc;
        wait_accept_w();
        wait_w(base + 1);
        check_eq("w_latency", last_w_cyc - acc, 2 + ((aw_wait > w_wait) ? aw_wait : w_wait));
        check_eq("awaddr", cap_awaddr, addr);
        check_eq("awlen", cap_awlen, 0);
        check_eq("awsize", cap_awsize, (mask == 2'b00) ? 0 : (mask == 2'b01) ? 1 : 2);
        check_eq("awburst", cap_awburst, 2'b01);
        check_eq("wdata", cap_wdata, exp_data);
        check_eq("wstrb", cap_wstrb, exp_strb);
        check_eq("wlast", cap_wlast, 1);
        repeat (3) tick();
        check_eq("w_single_pulse", wready_cnt, base + 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int rd_done;
        repeat (3) tick();
        // reset state (reset still high)
        check_eq("rst_valids", {ar_valid, aw_valid, w_valid}, 0);
        check_eq("rst_readies", {r_ready, b_ready, lsu_rready, lsu_wready}, 0);
        check_eq("rst_rdata", lsu_rdata, 0);
        reset = 0;
        tick();
        check_eq("idle_valids", {ar_valid, aw_valid, w_valid, r_ready, b_ready}, 0);

        // word read, zero wait
        do_single_read(32'h8000_0004, 2'b10, 1'b0, 32'hDEAD_BEEF, 8'h00);
        // byte read, signed and unsigned
        do_single_read(32'h8000_0003, 2'b00, 1'b1, 32'h8012_3456, 8'h05);
        do_single_read(32'h8000_0003, 2'b00, 1'b0, 32'h8012_3456, 8'h00);
        // half reads, both lanes
        do_single_read(32'h8000_0012, 2'b01, 1'b1, 32'h9ABC_1234, 8'h00);
        do_single_read(32'h8000_0010, 2'b01, 1'b0, 32'h9ABC_F234, 8'h00);
        // mask 11 behaves as word
        do_single_read(32'h8000_0020, 2'b11, 1'b1, 32'h8765_4321, 8'h00);

        // burst rlen=3 with 2-cycle gaps
        r_gap = 2;
        base = rready_cnt;
        for (int i = 0; i < 4; i++) begin
            rdata_tbl[i] = 32'h1111_0000 + 32'(i) * 32'h0101_0101 + 32'h80;
            exp_q.push_back(rdata_tbl[i]);
        end
        start_read(32'h8000_1000, 8'd3, 1'b1, 1'b1, 2'b00);
        wait_accept_r();
        wait_r(base + 4);
        repeat (6) tick();
        check_eq("burst_pulses", rready_cnt, base + 4);
        check_eq("burst_arlen", cap_arlen, 3);
        check_eq("burst_arburst", cap_arburst, 2'b01);
        check_eq("burst_arsize", cap_arsize, 2);
        check_eq("burst_q_empty", exp_q.size(), 0);
        r_gap = 0;

        // random single reads with random address stalls
        for (int k = 0; k < 6; k++) begin
            logic [1:0]  m;
            logic [1:0]  lo;
            m  = 2'($urandom_range(0, 3));
            lo = (m == 2'b00) ? 2'($urandom_range(0, 3)) :
                 (m == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            ar_wait = $urandom_range(0, 2);
            do_single_read({24'h8000_20, 6'($urandom_range(0, 63)), lo}, m,
                           1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 255)));
        end
        ar_wait = 0;

        // writes
        aw_wait = 3;
        do_write(32'h8000_0012, 32'h0000_1234, 2'b01, 32'h1234_1234, 4'b1100);
        aw_wait = 0;
        w_wait = 2;
        do_write(32'h8000_0021, 32'h0000_00AB, 2'b00, 32'hABAB_ABAB, 4'b0010);
        w_wait = 0;
        do_write(32'h8000_0030, 32'hCAFE_F00D, 2'b10, 32'hCAFE_F00D, 4'b1111);
        do_write(32'h8000_0040, 32'h0000_5678, 2'b01, 32'h5678_5678, 4'b0011);

        // read and write requested together: read first
        base = rready_cnt;
        rdata_tbl[0] = 32'h0BAD_F00D;
        exp_q.push_back(32'h0BAD_F00D);
        start_write(32'h8000_0050, 32'h0000_00EE, 2'b00);
        start_read(32'h8000_0060, 8'd0, 1'b0, 1'b0, 2'b10);
        wait_accept_r();
        wait_r(base + 1);
        rd_done = last_r_cyc;
        wait_accept_w();
        wait_w(wready_cnt + 1);
        check_eq("order_write_after_read", aw_hs_cyc > rd_done, 1);
        check_eq("both_wdata", cap_wdata, 32'hEEEE_EEEE);
        check_eq("both_wstrb", cap_wstrb, 4'b0001);
        repeat (2) tick();

        // reset in the middle of a burst
        base = rready_cnt;
        for (int i = 0; i < 8; i++) begin
            rdata_tbl[i] = 32'hA000_0000 + 32'(i);
            exp_q.push_back(rdata_tbl[i]);
        end
        start_read(32'h8000_2000, 8'd7, 1'b1, 1'b0, 2'b10);
        wait_accept_r();
        wait_r(base + 2);
        reset = 1;
        #1;
        check_eq("rst_mid_no_pulse", lsu_rready, 0);
        tick();
        reset = 0;
        #1;
        check_eq("rst_mid_valids", {ar_valid, aw_valid, w_valid}, 0);
        check_eq("rst_mid_readies", {r_ready, b_ready, lsu_rready, lsu_wready}, 0);
        check_eq("rst_mid_rdata", lsu_rdata, 0);
        repeat (6) tick();
        check_eq("rst_mid_no_more", rready_cnt, base + 2);
        check_eq("rst_mid_dropped", exp_q.size(), 6);
        exp_q.delete();

        // service resumes after reset
        do_single_read(32'h8000_0008, 2'b00, 1'b1, 32'h0000_7F00, 8'h00);

`ifdef YSYX_25040111_LSU_FAULT_EN
        begin
            int fbase = fault_cnt;
            bresp_cfg = 2'b10;
            do_write(32'h8000_0104, 32'h0000_0011, 2'b10, 32'h0000_0011, 4'b1111);
            check_eq("fault_flag", last_w_fault, 1);
            check_eq("fault_addr", last_w_fault_addr, 32'h8000_0104);
            check_eq("fault_cnt", fault_cnt, fbase + 1);
            bresp_cfg = 2'b00;
            do_write(32'h8000_0108, 32'h0000_0022, 2'b10, 32'h0000_0022, 4'b1111);
            check_eq("fault_okay", last_w_fault, 0);
        end
`endif

        check_eq("final_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
